dualport_ram_fifo_ctrl: RTL and testbench

//  Synchronous FIFO controller that sits directly upstream of the 64x16 single-enable dual-port RAM.
//  - RAM port 1 (addr1/DI/we) is the write port; RAM port 2 (addr2/DO2) is the read port.
//  - Exposes push/pop interfaces with full/empty/almost flags, an occupancy count and sticky error flags.
//  - Pop data is taken from the RAM's registered-address read port, one cycle after the pop is accepted.

---
 rtl/dualport_ram_fifo_ctrl_if.sv | 33 +++
 rtl/dualport_ram_fifo_ctrl.sv | 120 ++++++++++++
 tb/tb_dualport_ram_fifo_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dualport_ram_fifo_ctrl_if.sv
// User-side push/pop bundle for the dual-port RAM FIFO controller.
// The master drives requests; the slave (controller) returns data and status.
interface dualport_ram_fifo_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              flush;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              pop_valid;
  logic [DATA_W-1:0] pop_data;
  logic              full;
  logic              almost_full;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic              clear_err;

  modport master (
    output flush, push, push_data, pop, clear_err,
    input  pop_valid, pop_data, full, almost_full, empty, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  flush, push, push_data, pop, clear_err,
    output pop_valid, pop_data, full, almost_full, empty, almost_empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/dualport_ram_fifo_ctrl.sv
// Synchronous FIFO controller driving an external 64x16 single-enable dual-port RAM
// (port 1 writes, port 2 reads through a registered address).
module dualport_ram_fifo_ctrl #(
  parameter int ADDR_W        = 6,
  parameter int DATA_W        = 16,
  parameter int AFULL_THRESH  = 56,
  parameter int AEMPTY_THRESH = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  dualport_ram_fifo_ctrl_if.slave    fifo,
  output logic                       ram_en,
  output logic                       ram_we,
  output logic [ADDR_W-1:0]          ram_addr1,
  output logic [ADDR_W-1:0]          ram_addr2,
  output logic [DATA_W-1:0]          ram_di,
  input  logic [DATA_W-1:0]          ram_do2
);

  localparam logic [ADDR_W:0]   FULL_CNT   = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0]   AFULL_CNT  = (ADDR_W+1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0]   AEMPTY_CNT = (ADDR_W+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              pop_valid_reg, pop_valid_next;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;

  logic full_flag;
  logic empty_flag;
  logic push_ok;
  logic pop_ok;

  // Flags come from the registered count so they are stable for the whole cycle.
  assign full_flag  = (count_reg == FULL_CNT);
  assign empty_flag = (count_reg == '0);
  assign push_ok    = fifo.push & ~full_flag  & ~fifo.flush;
  assign pop_ok     = fifo.pop  & ~empty_flag & ~fifo.flush;

  assign fifo.full         = full_flag;
  assign fifo.empty        = empty_flag;
  assign fifo.almost_full  = (count_reg >= AFULL_CNT);
  assign fifo.almost_empty = (count_reg <= AEMPTY_CNT);
  assign fifo.count        = count_reg;
  assign fifo.pop_valid    = pop_valid_reg;
  assign fifo.pop_data     = ram_do2;
  assign fifo.overflow     = overflow_reg;
  assign fifo.underflow    = underflow_reg;

  // The RAM only latches its read address when enabled, so keep it enabled
  // outside reset; that way ram_do2 always reflects the head one cycle later.
  assign ram_en    = ~RST;
  assign ram_we    = push_ok & ~RST;
  assign ram_addr1 = wr_ptr_reg;
  assign ram_addr2 = rd_ptr_reg;
  assign ram_di    = fifo.push_data;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    pop_valid_next = pop_ok;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    if (fifo.flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_next = rd_ptr_reg + PTR_ONE;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase
    end

    // A clear in the same cycle as a new error wins.
    if (fifo.clear_err) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      if (fifo.push & full_flag) begin
        overflow_next = 1'b1;
      end
      if (fifo.pop & empty_flag) begin
        underflow_next = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      pop_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      pop_valid_reg <= pop_valid_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

endmodule

// File: tb/tb_dualport_ram_fifo_ctrl.sv
// Directed bench for dualport_ram_fifo_ctrl with a behavioural 64x16 dual-port RAM
// and a small queue model supplying the expected data, count and flags.
module tb_dualport_ram_fifo_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ram_en;
  logic        ram_we;
  logic [5:0]  ram_addr1;
  logic [5:0]  ram_addr2;
  logic [15:0] ram_di;
  logic [15:0] ram_do2;

  dualport_ram_fifo_ctrl_if #(.ADDR_W(6), .DATA_W(16)) u_if ();

  dualport_ram_fifo_ctrl #(
    .ADDR_W(6), .DATA_W(16), .AFULL_THRESH(56), .AEMPTY_THRESH(8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .fifo      (u_if.slave),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr1 (ram_addr1),
    .ram_addr2 (ram_addr2),
    .ram_di    (ram_di),
    .ram_do2   (ram_do2)
  );

  always #5 CLK = ~CLK;

  // RAM: write and read-address latch both gated by the single enable.
  logic [15:0] mem [0:63];
  logic [5:0]  rd_addr_reg;
  always @(posedge CLK) begin
    if (ram_en === 1'b1) begin
      if (ram_we === 1'b1) mem[ram_addr1] <= ram_di;
      rd_addr_reg <= ram_addr2;
    end
  end
  assign ram_do2 = mem[rd_addr_reg];

  int checks = 0;
  int errors = 0;

  int          mcount;
  logic [15:0] mq [$];
  logic [5:0]  mwr, mrd;
  logic        movf, munf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mcount = 0;
    mwr = '0;
    mrd = '0;
    movf = 1'b0;
    munf = 1'b0;
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cyc(input logic pu, input logic [15:0] d, input logic po,
                     input logic fl, input logic clr);
    logic        ep, eo;
    logic [15:0] hv;
    hv = '0;
    ep = pu && (mcount < 64) && !fl;
    eo = po && (mcount > 0) && !fl;
    u_if.push = pu;
    u_if.push_data = d;
    u_if.pop = po;
    u_if.flush = fl;
    u_if.clear_err = clr;
    #1;
    check_eq("ram_we", ram_we, ep);
    check_eq("ram_en", ram_en, 1'b1);
    check_eq("ram_addr1", ram_addr1, mwr);
    check_eq("ram_addr2", ram_addr2, mrd);
    check_eq("full", u_if.full, mcount == 64);
    check_eq("almost_full", u_if.almost_full, mcount >= 56);
    check_eq("empty", u_if.empty, mcount == 0);
    check_eq("almost_empty", u_if.almost_empty, mcount <= 8);
    if (ep) check_eq("ram_di", ram_di, d);

    if (clr) begin
      movf = 1'b0;
      munf = 1'b0;
    end else begin
      if (pu && mcount == 64) movf = 1'b1;
      if (po && mcount == 0)  munf = 1'b1;
    end
    if (fl) begin
      mq.delete();
      mwr = '0;
      mrd = '0;
    end else begin
      if (eo) begin
        hv = mq.pop_front();
        mrd = mrd + 6'd1;
      end
      if (ep) begin
        mq.push_back(d);
        mwr = mwr + 6'd1;
      end
    end
    mcount = mq.size();

    @(posedge CLK);
    #1;
    check_eq("count", u_if.count, mcount);
    check_eq("pop_valid", u_if.pop_valid, eo);
    if (eo) check_eq("pop_data", u_if.pop_data, hv);
    check_eq("overflow", u_if.overflow, movf);
    check_eq("underflow", u_if.underflow, munf);
    $display("cyc push=%0b pop=%0b flush=%0b clr=%0b -> count=%0d pop_valid=%0b pop_data=%04h",
             pu, po, fl, clr, u_if.count, u_if.pop_valid, u_if.pop_data);
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  // Two-cycle reset with push and optional pop held active to show they are discarded.
  task automatic do_reset(input logic po);
    u_if.push = 1'b1;
    u_if.push_data = 16'hDEAD;
    u_if.pop = po;
    u_if.flush = 1'b0;
    u_if.clear_err = 1'b0;
    RST = 1'b1;
    #1;
    check_eq("rst_ram_en", ram_en, 1'b0);
    check_eq("rst_ram_we", ram_we, 1'b0);
    @(posedge CLK);
    #1;
    check_eq("rst_pop_valid", u_if.pop_valid, 1'b0);
    check_eq("rst_count", u_if.count, 0);
    check_eq("rst_addr1", ram_addr1, 0);
    check_eq("rst_addr2", ram_addr2, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    u_if.push = 1'b0;
    u_if.pop = 1'b0;
    #1;
    check_eq("post_rst_ram_en", ram_en, 1'b1);
    check_eq("post_rst_empty", u_if.empty, 1'b1);
    check_eq("post_rst_almost_empty", u_if.almost_empty, 1'b1);
    check_eq("post_rst_full", u_if.full, 1'b0);
    check_eq("post_rst_almost_full", u_if.almost_full, 1'b0);
    check_eq("post_rst_overflow", u_if.overflow, 1'b0);
    check_eq("post_rst_underflow", u_if.underflow, 1'b0);
    $display("reset done pop_pending=%0b", po);
    model_reset();
  endtask

  initial begin
    RST = 1'b1;
    u_if.push = 1'b0;
    u_if.push_data = '0;
    u_if.pop = 1'b0;
    u_if.flush = 1'b0;
    u_if.clear_err = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;

    // Reset
    do_reset(1'b0);

    // Fill 0x0000..0x003F, then one push too many
    for (int i = 0; i < 64; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
    check_eq("fill_full", u_if.full, 1'b1);
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    check_eq("fill_overflow", u_if.overflow, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Drain in order, then one pop too many
    for (int i = 0; i < 64; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check_eq("drain_underflow", u_if.underflow, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Pointer wrap: 40 in / 40 out twice
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 40; i++) cyc(1'b1, 16'(16'h1000 + 16'(r * 64 + i)), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    end
    check_eq("wrap_wr_ptr", ram_addr1, 6'd16);

    // Steady state push+pop at count 10
    for (int i = 0; i < 10; i++) cyc(1'b1, 16'(16'h2000 + 16'(i)), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 16'(16'h2100 + 16'(i)), 1'b1, 1'b0, 1'b0);
    check_eq("steady_count", u_if.count, 10);
    for (int i = 0; i < 10; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    // Push+pop while empty: only the push lands
    cyc(1'b1, 16'h3333, 1'b1, 1'b0, 1'b0);
    check_eq("empty_pushpop_count", u_if.count, 1);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    idle();

    // Flush at count 30 with overflow already set
    for (int i = 0; i < 64; i++) cyc(1'b1, 16'(16'h4000 + 16'(i)), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 34; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check_eq("preflush_count", u_if.count, 30);
    cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    check_eq("flush_overflow_kept", u_if.overflow, 1'b1);
    check_eq("flush_pop_valid", u_if.pop_valid, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h5000 + 16'(i)), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream with a pop pending
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h6000 + 16'(i)), 1'b0, 1'b0, 1'b0);
    do_reset(1'b1);
    cyc(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
